// File: rtl/result_forward_pipe_pkg.sv
// Shared definitions for the EX-stage result forwarding pipe: default widths,
// the hard-wired zero register and the memory-wait FSM state encoding.
package result_forward_pipe_pkg;

  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned RW_DEF       = 5;
  localparam int unsigned WAIT_MAX_DEF = 15;

  localparam logic [RW_DEF-1:0] REG_ZERO = '0;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Control flags carried in the EX/MEM register
  typedef struct packed {
    logic regwr;
    logic memacc;
    logic load;
  } mem_ctl_t;

endpackage

// File: rtl/result_forward_pipe_mem_wait_fsm.sv
// Data-memory wait tracker: RUN/WAIT state, saturating wait counter and the
// sticky mem_err flag raised when a single access waits WAIT_MAX extra cycles.
module result_forward_pipe_mem_wait_fsm
  import result_forward_pipe_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_stall,
  output logic mem_err
);

  localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [0:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_nx;

  // State, counter and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mem_err <= err_nx;
    end
  end

  // Next state; the stalled access only completes when memory becomes ready
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = mem_err;
    case (state)
      ST_RUN: begin
        cnt_nx = '0;
        if (mem_stall) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_stall) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          if (cnt != CW'(WAIT_MAX)) cnt_nx = cnt + CW'(1);
          if (cnt_nx == CW'(WAIT_MAX)) err_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/result_forward_pipe.sv
// EX/MEM and MEM/WB result registers feeding the forwarding network and the
// register-file write port, plus load-use and memory-wait stall generation.
// Optional build macro STALL_CNT_EN adds a wrapping stall-cycle counter;
// without it stall_cycles is tied to zero.
module result_forward_pipe
  import result_forward_pipe_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned RW       = RW_DEF,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [RW-1:0] ex_rw,
  input  logic          ex_regwr,
  input  logic          ex_memtoreg,
  input  logic          ex_memwr,
  input  logic [DW-1:0] ex_alures,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [RW-1:0] Mem_Rw,
  output logic          Mem_RegWr,
  output logic [DW-1:0] Mem_ALUres,
  output logic          Mem_MemAcc,
  output logic [RW-1:0] Wr_Rw,
  output logic          Wr_RegWr,
  output logic [DW-1:0] Wr_res,
  output logic          load_use_stall,
  output logic          pipe_stall,
  output logic          mem_err,
  output logic [31:0]   stall_cycles
);

  mem_ctl_t ex_ctl, mem_ctl;
  logic     mem_stall;
  logic     ex_nz;
  logic     rw_hit;

  assign ex_nz      = (ex_rw != RW'(REG_ZERO));
  assign Mem_RegWr  = mem_ctl.regwr;
  assign Mem_MemAcc = mem_ctl.memacc;
  assign mem_stall  = mem_ctl.memacc & ~mem_ready;
  assign pipe_stall = mem_stall;

  // Load in EX whose destination is read by ID; the memory freeze wins
  assign rw_hit         = (ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt));
  assign load_use_stall = ~mem_stall & ex_valid & ex_memtoreg & ex_regwr & ex_nz & rw_hit;

  // EX control flags qualified by valid; writes to $0 are dropped here
  always_comb begin
    ex_ctl        = '0;
    ex_ctl.regwr  = ex_valid & ex_regwr & ex_nz;
    ex_ctl.memacc = ex_valid & (ex_memtoreg | ex_memwr);
    ex_ctl.load   = ex_valid & ex_memtoreg;
  end

  // EX/MEM register, frozen while memory is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      Mem_Rw     <= '0;
      Mem_ALUres <= '0;
      mem_ctl    <= '0;
    end else if (!mem_stall) begin
      Mem_Rw     <= ex_rw;
      Mem_ALUres <= ex_alures;
      mem_ctl    <= ex_ctl;
    end
  end

  // MEM/WB register; a memory wait sends a bubble into WB
  always_ff @(posedge clk) begin
    if (rst) begin
      Wr_Rw    <= '0;
      Wr_RegWr <= 1'b0;
      Wr_res   <= '0;
    end else if (!mem_stall) begin
      Wr_Rw    <= Mem_Rw;
      Wr_RegWr <= mem_ctl.regwr;
      Wr_res   <= mem_ctl.load ? mem_rdata : Mem_ALUres;
    end else begin
      Wr_RegWr <= 1'b0;
    end
  end

  result_forward_pipe_mem_wait_fsm #(
    .WAIT_MAX (WAIT_MAX)
  ) u_mem_wait_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Wrapping count of every frozen front-end cycle
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (load_use_stall | pipe_stall) stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/result_forward_pipe.md
Name: result_forward_pipe

Overview:
- Producer end of the EX-stage forwarding interface in the 5-stage MIPS pipeline.
- Holds the EX/MEM and MEM/WB pipeline registers for destination tag, write enable and result data. These drive Mem_Rw/Mem_RegWr/Mem_ALUres and Wr_Rw/Wr_RegWr/Wr_res, which the forwarding detector and operand muxes consume.
- Also generates the two stalls forwarding cannot cover: load-use and data-memory wait states. It feeds the register-file write port.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.
- WAIT_MAX, 15, max consecutive memory wait cycles before mem_err.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble).
- ex_rw  in  RW  EX destination register.
- ex_regwr  in  1  EX instruction writes a register.
- ex_memtoreg  in  1  EX instruction is a load.
- ex_memwr  in  1  EX instruction is a store.
- ex_alures  in  DW  EX ALU result.
- id_rs  in  RW  ID source register rs.
- id_rt  in  RW  ID source register rt.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- mem_ready  in  1  data memory completes the access this cycle.
- mem_rdata  in  DW  load data, valid when mem_ready.
- Mem_Rw  out  RW  MEM-stage destination.
- Mem_RegWr  out  1  MEM-stage write enable.
- Mem_ALUres  out  DW  MEM-stage ALU result, also the memory address.
- Mem_MemAcc  out  1  MEM stage holds a load or store.
- Wr_Rw  out  RW  WB destination, also the regfile write address.
- Wr_RegWr  out  1  WB write enable, also the regfile write enable.
- Wr_res  out  DW  WB result, also the regfile write data.
- load_use_stall  out  1  freeze PC and IF/ID, inject bubble into ID/EX.
- pipe_stall  out  1  freeze PC, IF/ID and ID/EX (memory wait).
- mem_err  out  1  sticky: memory wait exceeded WAIT_MAX.
- stall_cycles  out  32  stall statistics (see optional feature).

Behaviour:
- Reset: every register and output is 0. FSM goes to RUN; wait counter is 0; mem_err is 0.
- mem_stall (comb) = Mem_MemAcc & !mem_ready. pipe_stall = mem_stall.
- load_use_stall (comb) = ex_valid & ex_memtoreg & ex_regwr & (ex_rw!=0) & ((ex_rw==id_rs) | (id_uses_rt & ex_rw==id_rt)). It is masked to 0 while mem_stall is high, because the ID/EX freeze has priority.
- EX/MEM capture, when !mem_stall:
  - Mem_Rw <= ex_rw.
  - Mem_RegWr <= ex_valid & ex_regwr & (ex_rw!=0).
  - Mem_ALUres <= ex_alures.
  - Mem_MemAcc <= ex_valid & (ex_memtoreg | ex_memwr).
  - An internal Mem_Load <= ex_valid & ex_memtoreg.
- EX/MEM when mem_stall: all fields hold. Upstream holds ex_* stable under pipe_stall.
- MEM/WB capture, when !mem_stall:
  - Wr_Rw <= Mem_Rw.
  - Wr_RegWr <= Mem_RegWr.
  - Wr_res <= Mem_Load ? mem_rdata : Mem_ALUres.
- MEM/WB when mem_stall: Wr_RegWr <= 0 (bubble into WB). Wr_Rw and Wr_res hold.
- Latency: ALU result reaches Wr_res 2 cycles after EX with no stalls. Load data reaches it 1 cycle after mem_ready.
- FSM, 2 states:
  - RUN -> WAIT when mem_stall.
  - WAIT -> RUN when mem_ready. The access completes on that edge with normal capture.
  - WAIT -> WAIT otherwise, and the wait counter increments (saturating).
  - The counter clears on entry to RUN.
  - If the counter reaches WAIT_MAX, mem_err sets and stays set until rst. The pipeline keeps waiting; there is no forced completion.
- mem_ready while Mem_MemAcc=0 is ignored.
- A store with mem_ready=1 in the same cycle as a load in EX: no interaction; normal capture.
- Reset asserted mid-WAIT: everything returns to reset values next edge; in-flight access is discarded.
- A write to $0 never produces Mem_RegWr or Wr_RegWr = 1.

Optional Feature:
- STALL_CNT_EN defined: stall_cycles is a 32-bit wrapping counter.
  - Increments each cycle where load_use_stall | pipe_stall.
  - Cleared by rst.
- Undefined: the counter is not built and stall_cycles is tied to 0.

Decomposition:
- Shared package: DW/RW defaults, REG_ZERO constant, FSM state encoding RUN=1'b0 / WAIT=1'b1.
- One natural sub-module, mem_wait_fsm: FSM, wait counter, mem_err. The pipeline registers and stall logic stay in the top.

Test Plan:
- add $3 in EX (alures=0x10), no stalls -> cycle+1 Mem_Rw=3, Mem_RegWr=1, Mem_ALUres=0x10; cycle+2 Wr_Rw=3, Wr_RegWr=1, Wr_res=0x10.
- lw $5 in EX, ID reads rs=$5 -> load_use_stall=1 for exactly that cycle. Same with id_rt=5, id_uses_rt=0 -> load_use_stall=0.
- lw $5 in MEM, mem_ready low 3 cycles then high with rdata=0xCAFE -> pipe_stall=1 for 3 cycles, EX/MEM holds, Wr_RegWr=0 during wait; next cycle Wr_res=0xCAFE, Wr_RegWr=1.
- Instruction with ex_rw=0, ex_regwr=1 -> Mem_RegWr=0 and Wr_RegWr=0 throughout.
- mem_ready held low 16 cycles with WAIT_MAX=15 -> mem_err=1 and stays 1 after mem_ready returns; rst clears it and all outputs.
- STALL_CNT_EN defined, 1 load-use stall + 3 wait cycles -> stall_cycles=4. Undefined -> stall_cycles=0.
